// File: rtl/alu_lockstep_ctrl_pkg.sv
// Shared types and constants for the lockstep ALU self-test controller.
package alu_lockstep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int VEC_W   = 10;
  localparam int SEL_MSB = 9;
  localparam int B_LSB   = 4;
  localparam int A_LSB   = 0;
  localparam int ERR_W   = 11;

  localparam logic [VEC_W-1:0] SWEEP_LAST = 10'h3FF;
  localparam logic [ERR_W-1:0] ERR_MAX    = 11'h7FF;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_lockstep_ctrl_if.sv
// Control, status and dual-lane ALU bundle between the controller and its environment.
interface alu_lockstep_ctrl_if;
  import alu_lockstep_pkg::*;

  logic             start;
  logic             abort;
  logic             mode;
  logic [VEC_W-1:0] single_vec;
  logic             inject;
  logic [3:0]       a0, b0, a1, b1;
  logic [1:0]       sel0, sel1;
  logic [3:0]       alu_out0, alu_out1;
  logic             carry0, carry1;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_seen;
  logic [VEC_W-1:0] first_fail;

  modport slave (
    input  start, abort, mode, single_vec, inject,
    input  alu_out0, alu_out1, carry0, carry1,
    output a0, b0, a1, b1, sel0, sel1,
    output busy, done, err_cnt, fail_seen, first_fail
  );

  modport master (
    output start, abort, mode, single_vec, inject,
    output alu_out0, alu_out1, carry0, carry1,
    input  a0, b0, a1, b1, sel0, sel1,
    input  busy, done, err_cnt, fail_seen, first_fail
  );
endinterface

// File: rtl/alu_lockstep_ctrl_tag_pipe.sv
// Valid+tag shift register that tracks each issued vector until its ALU result is ready.
module lockstep_tag_pipe #(
  parameter int ALU_LAT = 1,
  parameter int W       = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_tag,
  output logic         o_valid,
  output logic [W-1:0] o_tag
);

  logic [ALU_LAT-1:0] r_valid;
  logic [W-1:0]       r_tag [ALU_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ALU_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= i_tag;
      for (int i = 1; i < ALU_LAT; i++) r_tag[i] <= r_tag[i-1];
      if (i_flush) begin
        r_valid <= '0;
      end else begin
        r_valid[0] <= i_valid;
        for (int i = 1; i < ALU_LAT; i++) r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign o_valid = r_valid[ALU_LAT-1];
  assign o_tag   = r_tag[ALU_LAT-1];

endmodule

// File: rtl/alu_lockstep_ctrl.sv
// Lockstep ALU self-test sequencer: drives both lanes, compares results, reports mismatches.
//   state | meaning
//   IDLE  | wait for start; status holds last run
//   RUN   | issue one vector per cycle
//   DRAIN | wait ALU_LAT cycles for in-flight results
//   DONE  | one-cycle done pulse, back to IDLE
module alu_lockstep_ctrl
  import alu_lockstep_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int VEC_W   = alu_lockstep_pkg::VEC_W
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  alu_lockstep_ctrl_if.slave bus
);

  localparam int DW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_e           r_state;
  logic             r_mode;
  logic [VEC_W-1:0] r_cnt;
  logic [VEC_W-1:0] r_vec;
  logic             r_inj;
  logic [DW-1:0]    r_drain;
  logic             r_busy;
  logic             r_done;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_fail_seen;
  logic [VEC_W-1:0] r_first_fail;

  logic             w_active;
  logic             w_abort;
  logic             w_last;
  logic             w_tag_valid;
  logic [VEC_W-1:0] w_tag;
  logic             w_mismatch;

  assign w_active = (r_state == RUN) || (r_state == DRAIN);
  assign w_abort  = w_active && bus.abort;
  assign w_last   = r_mode || (r_cnt == SWEEP_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_inj   <= 1'b0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= DONE;
        r_vec   <= '0;
        r_inj   <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_state <= RUN;
              r_mode  <= bus.mode;
              r_cnt   <= '0;
              r_vec   <= bus.mode ? bus.single_vec : '0;
              r_inj   <= bus.inject;
              r_busy  <= 1'b1;
            end
          end
          RUN: begin
            if (w_last) begin
              r_state <= DRAIN;
              r_drain <= DW'(ALU_LAT - 1);
              r_vec   <= '0;
              r_inj   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              r_vec <= r_cnt + 1'b1;
              r_inj <= bus.inject;
            end
          end
          DRAIN: begin
            if (r_drain == '0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_drain <= r_drain - 1'b1;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  lockstep_tag_pipe #(
    .ALU_LAT (ALU_LAT),
    .W       (VEC_W)
  ) u_tag_pipe (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .i_flush (w_abort),
    .i_valid (r_state == RUN),
    .i_tag   (r_vec),
    .o_valid (w_tag_valid),
    .o_tag   (w_tag)
  );

  assign w_mismatch = w_tag_valid &&
                      ((bus.alu_out0 != bus.alu_out1) || (bus.carry0 != bus.carry1));

  // A compare landing on the abort edge still counts; the flush only drops later ones.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_err_cnt    <= '0;
      r_fail_seen  <= 1'b0;
      r_first_fail <= '0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_err_cnt    <= '0;
      r_fail_seen  <= 1'b0;
      r_first_fail <= '0;
    end else if (w_mismatch) begin
      r_err_cnt   <= sat_inc(r_err_cnt);
      r_fail_seen <= 1'b1;
      if (!r_fail_seen) r_first_fail <= w_tag;
    end
  end

  assign bus.a0         = r_vec[A_LSB +: 4];
  assign bus.b0         = r_vec[B_LSB +: 4];
  assign bus.sel0       = r_vec[SEL_MSB -: 2];
  assign bus.a1         = r_vec[A_LSB +: 4] ^ {3'b000, r_inj};
  assign bus.b1         = r_vec[B_LSB +: 4];
  assign bus.sel1       = r_vec[SEL_MSB -: 2];
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.fail_seen  = r_fail_seen;
  assign bus.first_fail = r_first_fail;

endmodule
